// File: rtl/pp_framebuf_pkg.sv
// pp_framebuf_pkg: shared definitions for the ping-pong framebuffer.
//   state_t    - swap FSM states (IDLE, PENDING, CLEAR)
//   calc_w     - word width from bits per colour channel ({blue,green,red})
//   calc_aw    - bank address width from row/column index widths
//   disp_addr  - scanner (row, col) to bank address mapping
package pp_framebuf_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    CLEAR   = 2'd2
  } state_t;

  function automatic int unsigned calc_w(input int unsigned color_bits);
    return 3 * color_bits;
  endfunction

  function automatic int unsigned calc_aw(input int unsigned row_bits,
                                          input int unsigned col_bits);
    return row_bits + col_bits;
  endfunction

  // Address = {~col MSB, (row + row_offset) mod 2^row_bits, col low bits}.
  // The column MSB picks the half-panel; the inversion puts the upper half
  // in the lower half of the bank.
  function automatic logic [31:0] disp_addr(input logic [31:0] row,
                                            input logic [31:0] col,
                                            input int unsigned row_bits,
                                            input int unsigned col_bits,
                                            input int unsigned row_offset);
    logic [31:0] r;
    logic [31:0] c_lo;
    logic [31:0] msb;
    r    = (row + row_offset) & ((32'd1 << row_bits) - 32'd1);
    c_lo = col & ((32'd1 << (col_bits - 1)) - 32'd1);
    msb  = {31'd0, ~col[col_bits-1]};
    return (msb << (row_bits + col_bits - 1)) | (r << (col_bits - 1)) | c_lo;
  endfunction

endpackage

// File: rtl/sp_ram.sv
// sp_ram: single-port synchronous RAM, one access per clock.
//   clk    - clock
//   we     - write enable
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data; on a write it returns the old contents
module sp_ram #(
  parameter int unsigned DW = 8,
  parameter int unsigned AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pp_framebuf.sv
// pp_framebuf: ping-pong framebuffer between host/update logic and the LED
// panel scanner. The scanner reads the front bank; the host reads/writes the
// back bank. A host swap request is taken only at a scanner frame_end.
//
// Ports:
//   clk, reset                  - clock, asynchronous active-high reset
//   disp_rd, row, col           - scanner read strobe and pixel position
//   frame_end                   - scanner frame boundary pulse
//   disp_valid, red/green/blue  - front-bank pixel, 1 cycle after disp_rd
//   addr, we, re, data          - host access to the back bank
//   q, q_valid                  - host read data, 1 cycle after re (q holds)
//   swap_req, swap_pending      - swap request pulse / swap waiting for frame_end
//   front                       - bank index currently displayed
//   busy                        - back bank locked while it is being cleared
//
// Build option: define PP_FRAMEBUF_CLEAR_ON_SWAP_EN to zero the new back bank
// after every swap (CLEAR state, busy=1 for 2^AW cycles).
module pp_framebuf
  import pp_framebuf_pkg::*;
#(
  parameter int unsigned COLOR_BITS = 8,
  parameter int unsigned ROW_BITS   = 3,
  parameter int unsigned COL_BITS   = 6,
  parameter int unsigned ROW_OFFSET = 1,
  localparam int unsigned W  = calc_w(COLOR_BITS),
  localparam int unsigned AW = calc_aw(ROW_BITS, COL_BITS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  disp_rd,
  input  logic [ROW_BITS-1:0]   row,
  input  logic [COL_BITS-1:0]   col,
  input  logic                  frame_end,
  output logic                  disp_valid,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  input  logic [AW-1:0]         addr,
  input  logic                  we,
  input  logic                  re,
  input  logic [W-1:0]          data,
  output logic [W-1:0]          q,
  output logic                  q_valid,
  input  logic                  swap_req,
  output logic                  swap_pending,
  output logic                  front,
  output logic                  busy
);

  state_t        state;
  state_t        state_nxt;
  logic          swap_now;
  logic          disp_sel;
  logic          q_sel;
  logic [W-1:0]  q_hold;
  logic [AW-1:0] dsp_addr;
  logic [AW-1:0] back_addr;
  logic          back_we;
  logic [W-1:0]  back_wdata;
  logic [AW-1:0] bank0_addr;
  logic [AW-1:0] bank1_addr;
  logic          bank0_we;
  logic          bank1_we;
  logic [W-1:0]  bank0_rdata;
  logic [W-1:0]  bank1_rdata;
  logic [W-1:0]  pix;
  logic [W-1:0]  host_rd;

`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
  logic [AW-1:0] clr_cnt;
  logic          clr_req;

  assign busy         = (state == CLEAR);
  assign swap_pending = (state == PENDING) || ((state == CLEAR) && clr_req);
`else
  assign busy         = 1'b0;
  assign swap_pending = (state == PENDING);
`endif

  assign dsp_addr = AW'(disp_addr(32'(row), 32'(col), ROW_BITS, COL_BITS, ROW_OFFSET));

  // Swap FSM: swap_now marks the edge on which front toggles.
  always_comb begin
    state_nxt = state;
    swap_now  = 1'b0;
    case (state)
      IDLE: begin
        if (swap_req && frame_end) begin
          swap_now = 1'b1;
        end else if (swap_req) begin
          state_nxt = PENDING;
        end
      end
      PENDING: begin
        if (frame_end) begin
          swap_now = 1'b1;
        end
      end
`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
      CLEAR: begin
        // A request seen during the clear waits in PENDING for the next
        // frame_end after the clear, including one on the final clear cycle.
        if (clr_cnt == '1) begin
          state_nxt = (clr_req || swap_req) ? PENDING : IDLE;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
    if (swap_now) begin
`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
      state_nxt = CLEAR;
`else
      state_nxt = IDLE;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      front      <= 1'b0;
      disp_valid <= 1'b0;
      disp_sel   <= 1'b0;
      q_valid    <= 1'b0;
      q_sel      <= 1'b0;
      q_hold     <= '0;
    end else begin
      state      <= state_nxt;
      if (swap_now) begin
        front <= ~front;
      end
      disp_valid <= disp_rd;
      disp_sel   <= front;
      q_valid    <= re & ~busy;
      q_sel      <= ~front;
      if (q_valid) begin
        q_hold <= host_rd;
      end
    end
  end

`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_cnt <= '0;
      clr_req <= 1'b0;
    end else if (state == CLEAR) begin
      clr_cnt <= clr_cnt + AW'(1);
      if (clr_cnt == '1) begin
        clr_req <= 1'b0;
      end else if (swap_req) begin
        clr_req <= 1'b1;
      end
    end else begin
      clr_cnt <= '0;
      clr_req <= 1'b0;
    end
  end
`endif

  // Back-bank port: host access, or the clear counter while clearing.
  always_comb begin
    back_addr  = addr;
    back_we    = we & ~busy;
    back_wdata = data;
`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
    if (state == CLEAR) begin
      back_addr  = clr_cnt;
      back_we    = 1'b1;
      back_wdata = '0;
    end
`endif
  end

  // The front bank only ever sees the scanner address and never writes.
  assign bank0_addr = front ? back_addr : dsp_addr;
  assign bank1_addr = front ? dsp_addr : back_addr;
  assign bank0_we   = front & back_we;
  assign bank1_we   = ~front & back_we;

  sp_ram #(.DW(W), .AW(AW)) u_bank0 (
    .clk   (clk),
    .we    (bank0_we),
    .addr  (bank0_addr),
    .wdata (back_wdata),
    .rdata (bank0_rdata)
  );

  sp_ram #(.DW(W), .AW(AW)) u_bank1 (
    .clk   (clk),
    .we    (bank1_we),
    .addr  (bank1_addr),
    .wdata (back_wdata),
    .rdata (bank1_rdata)
  );

  // Read-select registers hold the issuing bank, so a read issued on the
  // swap edge still returns data from the bank it addressed.
  assign pix     = disp_sel ? bank1_rdata : bank0_rdata;
  assign host_rd = q_sel ? bank1_rdata : bank0_rdata;

  assign {blue, green, red} = disp_valid ? pix : '0;
  assign q                  = q_valid ? host_rd : q_hold;

endmodule

// File: tb/tb_pp_framebuf.sv
module tb_pp_framebuf;

  localparam int CB    = 8;
  localparam int RB    = 3;
  localparam int CLB   = 6;
  localparam int ROFF  = 1;
  localparam int AW    = RB + CLB;
  localparam int W     = 3 * CB;
  localparam int DEPTH = 1 << AW;
  localparam int HALF  = 1 << (CLB - 1);
  localparam int ROWS  = 1 << RB;
`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          disp_rd = 1'b0;
  logic [RB-1:0] row = '0;
  logic [CLB-1:0] col = '0;
  logic          frame_end = 1'b0;
  logic          disp_valid;
  logic [CB-1:0] red, green, blue;
  logic [AW-1:0] addr = '0;
  logic          we = 1'b0;
  logic          re = 1'b0;
  logic [W-1:0]  data = '0;
  logic [W-1:0]  q;
  logic          q_valid;
  logic          swap_req = 1'b0;
  logic          swap_pending;
  logic          front;
  logic          busy;

  always #5 clk = ~clk;

  pp_framebuf #(.COLOR_BITS(CB), .ROW_BITS(RB), .COL_BITS(CLB), .ROW_OFFSET(ROFF)) dut (
    .clk(clk), .reset(reset), .disp_rd(disp_rd), .row(row), .col(col),
    .frame_end(frame_end), .disp_valid(disp_valid), .red(red), .green(green),
    .blue(blue), .addr(addr), .we(we), .re(re), .data(data), .q(q),
    .q_valid(q_valid), .swap_req(swap_req), .swap_pending(swap_pending),
    .front(front), .busy(busy)
  );

  // Reference model: two banks as plain arrays plus swap bookkeeping.
  logic [W-1:0] mem [2][DEPTH];
  bit           m_front;
  bit           m_pend;
  int           m_busy;
  bit           e_dvalid;
  bit           e_qvalid;
  logic [W-1:0] e_pix;
  logic [W-1:0] e_q = '0;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic int dmap(input int r, input int c);
    return ((c >= HALF) ? 0 : DEPTH / 2) + ((r + ROFF) % ROWS) * HALF + (c % HALF);
  endfunction

  // Advance one clock: model consumes current inputs, then pulses drop.
  task automatic step();
    bit busy_now;
    int da;
    busy_now = (m_busy > 0);
    da = dmap(int'(row), int'(col));
    e_dvalid = disp_rd;
    if (disp_rd) e_pix = mem[m_front][da];
    e_qvalid = re && !busy_now;
    if (e_qvalid) e_q = mem[!m_front][addr];
    if (we && !busy_now) mem[!m_front][addr] = data;
    if (busy_now) begin
      if (swap_req) m_pend = 1'b1;
      m_busy--;
    end else if (frame_end && (m_pend || swap_req)) begin
      m_front = !m_front;
      m_pend  = 1'b0;
      if (CLEAR_EN) begin
        m_busy = DEPTH;
        for (int i = 0; i < DEPTH; i++) mem[!m_front][i] = '0;
      end
    end else if (swap_req) begin
      m_pend = 1'b1;
    end
    @(posedge clk);
    #1;
    disp_rd = 1'b0; we = 1'b0; re = 1'b0; swap_req = 1'b0; frame_end = 1'b0;
  endtask

  task automatic wait_idle();
    while (m_busy > 0) step();
  endtask

  task automatic fill_back(input bit use_const, input logic [W-1:0] val);
    for (int a = 0; a < DEPTH; a++) begin
      we = 1'b1; addr = AW'(a); data = use_const ? val : W'($urandom);
      step();
    end
  endtask

  task automatic test_reset();
    @(posedge clk); @(posedge clk); #1;
    n_checks++; if (front !== 1'b0) begin n_fail++; $display("FAIL reset_front: got %b want 0", front); end
    n_checks++; if (swap_pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending: got %b want 0", swap_pending); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (disp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dvalid: got %b want 0", disp_valid); end
    n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL reset_qvalid: got %b want 0", q_valid); end
    n_checks++; if ({blue, green, red} !== 24'h0) begin n_fail++; $display("FAIL reset_pix: got %h want 0", {blue, green, red}); end
    n_checks++; if (q !== 24'h0) begin n_fail++; $display("FAIL reset_q: got %h want 0", q); end
    @(negedge clk);
    reset = 1'b0;
    m_front = 1'b0; m_pend = 1'b0; m_busy = 0; e_q = '0;
  endtask

  task automatic test_fill();
    fill_back(1'b0, '0);
    swap_req = 1'b1; frame_end = 1'b1; step();
    n_checks++; if (front !== 1'b1) begin n_fail++; $display("FAIL fill_swap1: got %b want 1", front); end
    wait_idle();
    fill_back(1'b0, '0);
    swap_req = 1'b1; frame_end = 1'b1; step();
    n_checks++; if (front !== 1'b0) begin n_fail++; $display("FAIL fill_swap2: got %b want 0", front); end
    wait_idle();
  endtask

  task automatic test_host_rw();
    we = 1'b1; addr = '0; data = 24'h112233; step();
    re = 1'b1; addr = '0; step();
    n_checks++; if (q_valid !== 1'b1) begin n_fail++; $display("FAIL rw_qvalid: got %b want 1", q_valid); end
    n_checks++; if (q !== 24'h112233) begin n_fail++; $display("FAIL rw_q: got %h want 112233", q); end
    // Same location on the display side shows the front bank's old word.
    disp_rd = 1'b1; row = 3'd7; col = 6'h20; step();
    n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL rw_qvalid_drop: got %b want 0", q_valid); end
    n_checks++; if (q !== 24'h112233) begin n_fail++; $display("FAIL rw_q_hold: got %h want 112233", q); end
    n_checks++; if (disp_valid !== 1'b1 || {blue, green, red} !== e_pix) begin
      n_fail++; $display("FAIL rw_disp_old: got %b/%h want 1/%h", disp_valid, {blue, green, red}, e_pix); end
    we = 1'b1; re = 1'b1; addr = '0; data = 24'h445566; step();
    n_checks++; if (q !== 24'h112233) begin n_fail++; $display("FAIL rw_rbw: got %h want 112233", q); end
    re = 1'b1; addr = '0; step();
    n_checks++; if (q !== 24'h445566) begin n_fail++; $display("FAIL rw_after_write: got %h want 445566", q); end
  endtask

  task automatic test_swap_pending();
    bit f0;
    f0 = m_front;
    we = 1'b1; addr = 9'({1'b0, 3'd1, 5'd0}); data = 24'hAABBCC; step();
    swap_req = 1'b1; step();
    for (int i = 0; i < 10; i++) begin
      n_checks++; if (swap_pending !== 1'b1 || front !== f0) begin
        n_fail++; $display("FAIL pend_wait[%0d]: got pend=%b front=%b want 1/%b", i, swap_pending, front, f0); end
      step();
    end
    frame_end = 1'b1; step();
    n_checks++; if (front !== !f0 || swap_pending !== 1'b0) begin
      n_fail++; $display("FAIL pend_swap: got front=%b pend=%b want %b/0", front, swap_pending, !f0); end
    disp_rd = 1'b1; row = 3'd0; col = 6'h20; step();
    n_checks++; if ({blue, green, red} !== 24'hAABBCC) begin
      n_fail++; $display("FAIL pend_pix: got %h want aabbcc", {blue, green, red}); end
    wait_idle();
  endtask

  task automatic test_immediate_swap();
    bit f0;
    f0 = m_front;
    swap_req = 1'b1; frame_end = 1'b1; step();
    n_checks++; if (front !== !f0 || swap_pending !== 1'b0) begin
      n_fail++; $display("FAIL imm_swap: got front=%b pend=%b want %b/0", front, swap_pending, !f0); end
    wait_idle();
    for (int k = 0; k < 3; k++) begin
      swap_req = 1'b1; step();
      n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL imm_absorb[%0d]: got %b want 1", k, swap_pending); end
      step();
    end
    frame_end = 1'b1; step();
    n_checks++; if (front !== f0) begin n_fail++; $display("FAIL imm_one_toggle: got %b want %b", front, f0); end
    frame_end = 1'b1; step();
    n_checks++; if (front !== f0 || swap_pending !== 1'b0) begin
      n_fail++; $display("FAIL imm_no_second: got front=%b pend=%b want %b/0", front, swap_pending, f0); end
    wait_idle();
  endtask

  task automatic test_addr_map();
    logic [CLB-1:0] edge_cols [2];
    edge_cols[0] = 6'h00; edge_cols[1] = 6'h3F;
    for (int k = 0; k < 2; k++) begin
      disp_rd = 1'b1; row = 3'd7; col = edge_cols[k]; step();
      n_checks++; if ({blue, green, red} !== mem[m_front][(k == 0) ? 256 : 31]) begin
        n_fail++; $display("FAIL map_edge col=%h: got %h want %h", edge_cols[k], {blue, green, red}, mem[m_front][(k == 0) ? 256 : 31]); end
    end
    for (int i = 0; i < 40; i++) begin
      disp_rd = 1'b1; row = 3'($urandom); col = 6'($urandom); step();
      n_checks++; if ({blue, green, red} !== e_pix) begin
        n_fail++; $display("FAIL map_rand[%0d]: got %h want %h", i, {blue, green, red}, e_pix); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 2000; i++) begin
      disp_rd = 1'($urandom); row = 3'($urandom); col = 6'($urandom);
      we = ($urandom_range(0, 2) == 0); re = ($urandom_range(0, 2) == 0);
      addr = 9'($urandom); data = 24'($urandom);
      swap_req = ($urandom_range(0, 19) == 0); frame_end = ($urandom_range(0, 29) == 0);
      step();
      n_checks++; if (disp_valid !== e_dvalid) begin n_fail++; $display("FAIL rnd_dvalid[%0d]: got %b want %b", i, disp_valid, e_dvalid); end
      if (e_dvalid) begin
        n_checks++; if ({blue, green, red} !== e_pix) begin n_fail++; $display("FAIL rnd_pix[%0d]: got %h want %h", i, {blue, green, red}, e_pix); end
      end
      n_checks++; if (q_valid !== e_qvalid) begin n_fail++; $display("FAIL rnd_qvalid[%0d]: got %b want %b", i, q_valid, e_qvalid); end
      n_checks++; if (q !== e_q) begin n_fail++; $display("FAIL rnd_q[%0d]: got %h want %h", i, q, e_q); end
      n_checks++; if (front !== m_front || swap_pending !== m_pend || busy !== (m_busy > 0)) begin
        n_fail++; $display("FAIL rnd_ctrl[%0d]: got f=%b p=%b b=%b want %b/%b/%b", i, front, swap_pending, busy, m_front, m_pend, m_busy > 0); end
    end
    wait_idle();
  endtask

  task automatic test_async_reset();
    swap_req = 1'b1; step();
    n_checks++; if (swap_pending !== 1'b1) begin n_fail++; $display("FAIL ar_pend_before: got %b want 1", swap_pending); end
    #2 reset = 1'b1;
    #1;
    n_checks++; if (swap_pending !== 1'b0 || front !== 1'b0) begin
      n_fail++; $display("FAIL ar_cleared: got pend=%b front=%b want 0/0", swap_pending, front); end
    m_front = 1'b0; m_pend = 1'b0; m_busy = 0; e_q = '0;
    @(negedge clk);
    reset = 1'b0;
    frame_end = 1'b1; step();
    n_checks++; if (front !== 1'b0 || swap_pending !== 1'b0) begin
      n_fail++; $display("FAIL ar_no_toggle: got front=%b pend=%b want 0/0", front, swap_pending); end
  endtask

`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
  task automatic test_clear();
    int cnt;
    int guard;
    fill_back(1'b1, 24'hFFFFFF);
    swap_req = 1'b1; frame_end = 1'b1; step();
    wait_idle();
    fill_back(1'b1, 24'hFFFFFF);
    swap_req = 1'b1; frame_end = 1'b1; step();
    cnt = 0; guard = 0;
    while (busy === 1'b1 && guard < 2000) begin
      we = 1'b1; re = 1'b1; addr = 9'($urandom); data = 24'($urandom);
      step();
      n_checks++; if (q_valid !== 1'b0) begin n_fail++; $display("FAIL clr_qvalid_busy: got %b want 0", q_valid); end
      cnt++; guard++;
    end
    n_checks++; if (cnt !== DEPTH) begin n_fail++; $display("FAIL clr_busy_len: got %0d want %0d", cnt, DEPTH); end
    for (int a = 0; a < DEPTH; a++) begin
      re = 1'b1; addr = AW'(a); step();
      n_checks++; if (q_valid !== 1'b1 || q !== 24'h0) begin
        n_fail++; $display("FAIL clr_word[%0d]: got %b/%h want 1/000000", a, q_valid, q); end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_host_rw();
    test_swap_pending();
    test_immediate_swap();
    test_addr_map();
    test_random();
    test_async_reset();
`ifdef PP_FRAMEBUF_CLEAR_ON_SWAP_EN
    test_clear();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
